// File: rtl/rfphoenix_pfx_assembler.sv
// Fetch-to-decode front end: folds PFX postfix words into the following instruction
// and hands {ir, pfx, pc} bundles to the decoder through a 2-entry skid buffer.
module rfphoenix_pfx_assembler #(
  parameter int         AW     = 32,
  parameter int         DEPTH  = 2,
  parameter logic [6:0] PFX_OP = 7'h0B
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [31:0]   in_word_i,
  input  logic [AW-1:0] in_pc_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [31:0]   out_ir_o,
  output logic [31:0]   out_pfx_o,
  output logic [AW-1:0] out_pc_o,
  output logic          pfx_dup_o
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  typedef struct packed {
    logic [31:0]   ir;
    logic [31:0]   pfx;
    logic [AW-1:0] pc;
  } entry_t;

  typedef enum logic {IDLE, HAVE_PFX} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pfx_q, pfx_d;
  logic [AW-1:0] grp_pc_q, grp_pc_d;
  entry_t        mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]    count_q, count_d;
  logic          dup_q, dup_d;

  logic   accept, is_pfx, push, pop;
  entry_t push_entry;

  assign in_ready_o = (count_q < FULL) & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;
  assign is_pfx     = (in_word_i[6:0] == PFX_OP);
  assign pop        = (count_q != 2'd0) & out_ready_i;

  always_comb begin
    state_d    = state_q;
    pfx_d      = pfx_q;
    grp_pc_d   = grp_pc_q;
    dup_d      = 1'b0;
    push       = 1'b0;
    push_entry = '{ir: in_word_i, pfx: 32'h0, pc: in_pc_i};
    if (flush_i) begin
      state_d = IDLE;
      pfx_d   = 32'h0;
    end else if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (is_pfx) begin
            pfx_d    = in_word_i;
            grp_pc_d = in_pc_i;
            state_d  = HAVE_PFX;
          end else begin
            push = 1'b1;
          end
        end
        HAVE_PFX: begin
          if (is_pfx) begin
            // Latest postfix wins; the group keeps the pc of the oldest one.
            pfx_d = in_word_i;
            dup_d = 1'b1;
          end else begin
            push           = 1'b1;
            push_entry.pfx = pfx_q;
            push_entry.pc  = grp_pc_q;
            pfx_d          = 32'h0;
            state_d        = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift-style FIFO: mem0 is always the head so outputs come straight from flops.
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b01: begin
          mem0_d  = mem1_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) mem0_d = push_entry;
          else                 mem1_d = push_entry;
          count_d = count_q + 2'd1;
        end
        2'b11: mem0_d = push_entry;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      pfx_q    <= 32'h0;
      grp_pc_q <= '0;
      mem0_q   <= '0;
      mem1_q   <= '0;
      count_q  <= 2'd0;
      dup_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pfx_q    <= pfx_d;
      grp_pc_q <= grp_pc_d;
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      count_q  <= count_d;
      dup_q    <= dup_d;
    end
  end

  assign out_valid_o = (count_q != 2'd0);
  assign out_ir_o    = mem0_q.ir;
  assign out_pfx_o   = mem0_q.pfx;
  assign out_pc_o    = mem0_q.pc;
  assign pfx_dup_o   = dup_q;

endmodule

// File: tb/tb_rfphoenix_pfx_assembler.sv
// Directed plus randomized bench for rfphoenix_pfx_assembler against a queue-based
// model of bundles, pending postfix and duplicate-postfix pulses.
module tb_rfphoenix_pfx_assembler;

  localparam int         AW     = 32;
  localparam logic [6:0] PFX_OP = 7'h0B;

  logic          clk_i = 1'b0;
  logic          rst_ni, flush_i, in_valid_i, out_ready_i;
  logic          in_ready_o, out_valid_o, pfx_dup_o;
  logic [31:0]   in_word_i, out_ir_o, out_pfx_o;
  logic [AW-1:0] in_pc_i, out_pc_o;

  rfphoenix_pfx_assembler #(.AW(AW), .DEPTH(2), .PFX_OP(PFX_OP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_word_i(in_word_i), .in_pc_i(in_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_ir_o(out_ir_o), .out_pfx_o(out_pfx_o), .out_pc_o(out_pc_o),
    .pfx_dup_o(pfx_dup_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pfx;
    logic [31:0] pc;
  } bundle_t;

  bundle_t     q[$];
  bit          pend, exp_dup, fresh;
  logic [31:0] pend_word, pend_pc;
  int          checks, errors;

  function automatic logic [31:0] pfxWord(input logic [15:0] imm);
    return {imm, 9'h0, PFX_OP};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs against the model, then advance the model.
  task automatic applyStimulus(input bit v, input logic [31:0] w, input logic [31:0] pc,
                               input bit ordy, input bit fl, input bit rst_n);
    bit      exp_ready, acc, pop, ispfx;
    bundle_t b;
    in_valid_i = v; in_word_i = w; in_pc_i = pc;
    out_ready_i = ordy; flush_i = fl; rst_ni = rst_n;
    #1;
    exp_ready = (q.size() < 2) && !fl;
    checkOutput("in_ready", 64'(in_ready_o), 64'(exp_ready));
    checkOutput("out_valid", 64'(out_valid_o), 64'(q.size() > 0));
    checkOutput("pfx_dup", 64'(pfx_dup_o), 64'(exp_dup));
    if (q.size() > 0) begin
      checkOutput("out_ir", 64'(out_ir_o), 64'(q[0].ir));
      checkOutput("out_pfx", 64'(out_pfx_o), 64'(q[0].pfx));
      checkOutput("out_pc", 64'(out_pc_o), 64'(q[0].pc));
    end else if (fresh) begin
      checkOutput("reset_zero", {out_ir_o, out_pfx_o | out_pc_o}, 64'h0);
    end
    acc   = v && exp_ready;
    pop   = (q.size() > 0) && ordy;
    ispfx = (w[6:0] == PFX_OP);
    @(posedge clk_i);
    exp_dup = 1'b0;
    if (!rst_n) begin
      q.delete(); pend = 1'b0; fresh = 1'b1;
    end else if (fl) begin
      q.delete(); pend = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        if (ispfx) begin
          if (pend) exp_dup = 1'b1;
          else      pend_pc = pc;
          pend      = 1'b1;
          pend_word = w;
        end else begin
          b.ir  = w;
          b.pfx = pend ? pend_word : 32'h0;
          b.pc  = pend ? pend_pc : pc;
          q.push_back(b);
          pend  = 1'b0;
          fresh = 1'b0;
        end
      end
    end
    @(negedge clk_i);
  endtask

  task automatic step(input bit v, input logic [31:0] w, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    applyStimulus(v, w, pc, ordy, fl, 1'b1);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, ordy, 1'b0);
  endtask

  localparam logic [31:0] I1   = 32'h00100013;
  localparam logic [31:0] I2   = 32'h00200013;
  localparam logic [31:0] ADDI = 32'h02A30293;
  localparam logic [31:0] LDT  = 32'h0004A503;

  initial begin
    logic [31:0] w, pc;
    bit          v, ordy, fl, rn;
    checks = 0; errors = 0;
    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    in_word_i = 32'h0; in_pc_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    q.delete(); pend = 1'b0; exp_dup = 1'b0; fresh = 1'b1;
    rst_ni = 1'b1;

    // Plain instruction stream
    step(1, I1, 32'h100, 1, 0);
    step(1, I2, 32'h104, 1, 0);
    idle(2, 1);

    // Postfix folded into ADDI
    step(1, pfxWord(16'h1234), 32'h200, 1, 0);
    step(1, ADDI, 32'h204, 1, 0);
    idle(2, 1);

    // Duplicate postfix: latest imm, oldest pc
    step(1, pfxWord(16'hAAAA), 32'h300, 1, 0);
    step(1, pfxWord(16'h5555), 32'h304, 1, 0);
    step(1, LDT, 32'h308, 1, 0);
    idle(2, 1);

    // Backpressure: third word waits until a slot frees
    step(1, 32'h00A00013, 32'h500, 0, 0);
    step(1, 32'h00B00013, 32'h504, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h00C00013, 32'h508, 0, 0);
    step(1, 32'h00C00013, 32'h508, 1, 0);
    step(1, 32'h00C00013, 32'h508, 1, 0);
    idle(3, 1);

    // Flush with a bundle waiting and a postfix pending
    step(1, I1, 32'h3F0, 0, 0);
    step(1, pfxWord(16'hBEEF), 32'h3F4, 0, 0);
    step(0, 32'h0, 32'h0, 1, 1);
    step(1, I2, 32'h400, 1, 0);
    idle(2, 1);

    // Reset with buffered bundle and pending postfix
    step(1, I1, 32'h600, 0, 0);
    step(1, pfxWord(16'h0F0F), 32'h604, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 0);
    step(1, I2, 32'h608, 1, 0);
    idle(2, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      w  = $urandom;
      if ($urandom_range(0, 2) == 0) w = pfxWord(16'($urandom));
      else if (w[6:0] == PFX_OP) w[0] = ~w[0];
      pc   = $urandom & 32'hFFFF_FFFC;
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      rn   = ($urandom_range(0, 99) != 0);
      applyStimulus(v, w, pc, ordy, fl, rn);
    end
    idle(4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
